// File: rtl/ni_axis_arb_pkg.sv
// Shared types and constants for the packet-granular AXI4-Stream arbiter.
package ni_axis_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  localparam int PKT_COUNT_WIDTH = 16;

endpackage

// File: rtl/ni_rr_pick.sv
// Combinational round-robin selector: first asserted request scanning upward
// from (last_grant+1) mod NUM_INPUTS.
module ni_rr_pick #(
  parameter int NUM_INPUTS = 4,
  parameter int IDX_WIDTH  = $clog2(NUM_INPUTS)
) (
  input  logic [NUM_INPUTS-1:0] req,
  input  logic [IDX_WIDTH-1:0]  last_grant,
  output logic                  any_req,
  output logic [IDX_WIDTH-1:0]  winner
);

  logic [IDX_WIDTH-1:0] idx;

  // Walk offsets from farthest to nearest so the closest requester wins last.
  always_comb begin
    any_req = |req;
    winner  = last_grant;
    idx     = '0;
    for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
      idx = IDX_WIDTH'((32'(last_grant) + (NUM_INPUTS - k)) % NUM_INPUTS);
      if (req[idx]) winner = idx;
    end
  end

endmodule

// File: rtl/ni_axis_packet_arbiter.sv
// Packet-granular round-robin AXI4-Stream arbiter with registered output.
// Optional per-source packet counters enabled by NI_AXIS_ARB_PKT_COUNT_EN.
module ni_axis_packet_arbiter
  import ni_axis_arb_pkg::*;
#(
  parameter int NUM_INPUTS = 4,
  parameter int DATA_WIDTH = 64,
  parameter int DEST_WIDTH = 8,
  parameter int ID_WIDTH   = 4
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic [NUM_INPUTS-1:0]            s_axis_tvalid,
  output logic [NUM_INPUTS-1:0]            s_axis_tready,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_INPUTS*DEST_WIDTH-1:0] s_axis_tdest,
  input  logic [NUM_INPUTS-1:0]            s_axis_tlast,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic [DATA_WIDTH-1:0]            m_axis_tdata,
  output logic [DEST_WIDTH-1:0]            m_axis_tdest,
  output logic [ID_WIDTH-1:0]              m_axis_tid,
  output logic                             m_axis_tlast
`ifdef NI_AXIS_ARB_PKT_COUNT_EN
  ,
  output logic [NUM_INPUTS*PKT_COUNT_WIDTH-1:0] pkt_count
`endif
);

  localparam int IDX_WIDTH = $clog2(NUM_INPUTS);

  arb_state_t           state;
  logic [IDX_WIDTH-1:0] grant;
  logic [IDX_WIDTH-1:0] last_grant;
  logic [IDX_WIDTH-1:0] winner;
  logic                 any_req;
  logic                 out_ready;
  logic                 accept;
  logic                 sel_last;

  ni_rr_pick #(
    .NUM_INPUTS (NUM_INPUTS),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_pick (
    .req        (s_axis_tvalid),
    .last_grant (last_grant),
    .any_req    (any_req),
    .winner     (winner)
  );

  assign out_ready = !m_axis_tvalid || m_axis_tready;
  assign accept    = (state == ARB_LOCKED) && s_axis_tvalid[grant] && out_ready;
  assign sel_last  = s_axis_tlast[grant];

  always_comb begin
    s_axis_tready = '0;
    if (state == ARB_LOCKED) s_axis_tready[grant] = out_ready;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= ARB_IDLE;
      grant      <= '0;
      last_grant <= IDX_WIDTH'(NUM_INPUTS - 1);
    end else begin
      case (state)
        ARB_IDLE: begin
          if (any_req) begin
            grant      <= winner;
            last_grant <= winner;
            state      <= ARB_LOCKED;
          end
        end
        ARB_LOCKED: begin
          if (accept && sel_last) state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tdest  <= '0;
      m_axis_tid    <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (accept) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= s_axis_tdata[grant*DATA_WIDTH +: DATA_WIDTH];
      m_axis_tdest  <= s_axis_tdest[grant*DEST_WIDTH +: DEST_WIDTH];
      m_axis_tid    <= ID_WIDTH'(grant);
      m_axis_tlast  <= sel_last;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

`ifdef NI_AXIS_ARB_PKT_COUNT_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pkt_count <= '0;
    end else if (accept && sel_last) begin
      for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
        if (grant == IDX_WIDTH'(i))
          pkt_count[i*PKT_COUNT_WIDTH +: PKT_COUNT_WIDTH] <=
            pkt_count[i*PKT_COUNT_WIDTH +: PKT_COUNT_WIDTH] + 1'b1;
      end
    end
  end
`endif

endmodule

// File: doc/ni_axis_packet_arbiter.md
# ni_axis_packet_arbiter

Packet-granular round-robin arbiter that shares the single AXI4-Stream injection port of the single-unit network interface among NUM_INPUTS local requesters. A grant is held for a whole packet, from first beat through TLAST, so flits of different packets never interleave at the network interface. The output is a registered stage, and TID carries the index of the granted source.

## Interface
Parameters:
- NUM_INPUTS, 4: number of requesting AXI4-Stream sources; legal range 2..16.
- DATA_WIDTH, 64: TDATA width in bits.
- DEST_WIDTH, 8: TDEST width; passed through unmodified.
- ID_WIDTH, 4: TID width; must be at least $clog2(NUM_INPUTS).

Ports:
- aclk  in  1  single clock for the whole block.
- aresetn  in  1  asynchronous active-low reset.
- s_axis_tvalid  in  NUM_INPUTS  per-source valid.
- s_axis_tready  out  NUM_INPUTS  per-source ready.
- s_axis_tdata  in  NUM_INPUTS*DATA_WIDTH  packed per-source data; source i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
- s_axis_tdest  in  NUM_INPUTS*DEST_WIDTH  packed per-source destination.
- s_axis_tlast  in  NUM_INPUTS  per-source end-of-packet.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready from the network interface.
- m_axis_tdata  out  DATA_WIDTH  output data.
- m_axis_tdest  out  DEST_WIDTH  output destination.
- m_axis_tid  out  ID_WIDTH  index of the granted source, zero-extended.
- m_axis_tlast  out  1  output end-of-packet.

## Operation
- FSM states: IDLE and LOCKED.
- IDLE:
  - If any s_axis_tvalid is high, select the first asserted source scanning upward from (last_grant+1) mod NUM_INPUTS.
  - Register the winner as grant and last_grant, then move to LOCKED.
  - All s_axis_tready are 0 in IDLE.
- LOCKED:
  - s_axis_tready[grant] = out_ready. All other readies are 0.
  - out_ready = !m_axis_tvalid || m_axis_tready.
  - A beat is accepted when s_axis_tvalid[grant] && s_axis_tready[grant].
  - An accepted beat loads tdata, tdest, tlast and tid=grant into the output register.
  - An accepted beat with tlast=1 returns the FSM to IDLE.
- Output register:
  - Sets m_axis_tvalid on a load.
  - Clears m_axis_tvalid when m_axis_tready is high and no new load occurs.
  - A load and a drain in the same cycle replace the contents, keeping valid at 1.
- Source rules:
  - A source must not drop tvalid mid-packet.
  - If it does, the arbiter stays LOCKED and waits. No timeout exists.
- Reset, including mid-packet:
  - State goes to IDLE, last_grant to NUM_INPUTS-1, so source 0 has first priority.
  - The output register is cleared. A partially sent packet is discarded and is not completed.
- Single-beat packets (tlast on the first beat) are legal and return to IDLE after one beat.

## Timing
- Reset values: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tdest=0, m_axis_tid=0, m_axis_tlast=0, s_axis_tready=0.
- Arbitration costs one cycle: the IDLE cycle in which the winner is chosen accepts no beat.
- Latency from input handshake to m_axis_tvalid is 1 cycle.
- Within a packet, with m_axis_tready held high, throughput is 1 beat/cycle.
- Per-packet overhead is 1 bubble cycle (the IDLE cycle).
- No combinational path from any s_axis_* input to any m_axis_* output.
- The only combinational path is m_axis_tready to s_axis_tready[grant].

## Configuration
- Macro: NI_AXIS_ARB_PKT_COUNT_EN.
- Defined:
  - Adds output pkt_count, width NUM_INPUTS*16, out. Slice i counts packets completed by source i, i.e. accepted beats with tlast=1.
  - Counters wrap from 16'hFFFF to 0 and reset to 0.
- Undefined: the port and the counters do not exist.

## Structure
- Shared package ni_axis_arb_pkg holds:
  - typedef arb_state_t {ARB_IDLE, ARB_LOCKED};
  - localparam PKT_COUNT_WIDTH=16.
- One sub-module, ni_rr_pick: purely combinational round-robin priority selector.
  - Inputs: req[NUM_INPUTS], last_grant.
  - Outputs: any_req and the winner index.
- The FSM, output register and optional counters live in the top module.

## Test plan
- Reset priority: after reset, sources 0 and 2 each present a 3-beat packet simultaneously, m_axis_tready=1.
  - Output order is source 0 beats (tid=0) then source 2 beats (tid=2).
  - Each packet is preceded by exactly one idle cycle.
- Rotation: all 4 sources continuously send 1-beat packets.
  - tid sequence is 0,1,2,3,0,1…
  - One output beat every 2 cycles.
- No interleave: source 1 sends an 8-beat packet while source 3 asserts tvalid from the second beat onward.
  - All 8 source-1 beats are contiguous on the output before any tid=3 beat.
- Backpressure: m_axis_tready toggles 1,0,1,0 during a 4-beat packet with data 0x10..0x13.
  - Output data is 0x10..0x13 in order, with none lost or duplicated.
  - s_axis_tready[grant] is low whenever m_axis_tvalid=1 and m_axis_tready=0.
- Reset mid-packet: assert aresetn=0 after beat 2 of a 5-beat packet.
  - m_axis_tvalid=0 immediately (asynchronous).
  - After release, a new packet from source 0 is granted first.
- Counters (with NUM_INPUTS=4 and NI_AXIS_ARB_PKT_COUNT_EN defined): source 2 completes 3 packets and source 0 completes 1.
  - pkt_count slice 2 reads 3, slice 0 reads 1, the others read 0.
